// File: rtl/proc_wb_buffer_pkg.sv
// ----------------------------------------------------------------------------
// proc_wb_buffer_pkg
//  Shared types and constants for the writeback buffer.
//  - WB_* localparams : default geometry of the buffer; the entry struct is
//                       sized from them, so the top-level width parameters
//                       must keep these values.
//  - REG_ZERO         : the hard-wired zero register specifier (never stored,
//                       never matched by a lookup).
//  - wb_entry_t       : one queued result {destination register, value}.
//  - wb_count_t       : occupancy counter type for the default depth.
// ----------------------------------------------------------------------------
package proc_wb_buffer_pkg;

    localparam int WB_NUM_ENTRIES = 4;
    localparam int WB_DATA_NBITS  = 32;
    localparam int WB_ADDR_NBITS  = 5;

    localparam logic [WB_ADDR_NBITS-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_NBITS-1:0] addr;
        logic [WB_DATA_NBITS-1:0] data;
    } wb_entry_t;

    typedef logic [$clog2(WB_NUM_ENTRIES+1)-1:0] wb_count_t;

endpackage

// File: rtl/proc_wb_buffer_match.sv
// ----------------------------------------------------------------------------
// proc_wb_buffer_match
//  Bypass lookup for one query port: compares the query register against
//  every valid queue slot and returns the youngest (closest to tail) match.
//  Ports:
//   entries_i  in  queue storage, indexed by physical slot
//   valid_i    in  per-slot occupancy
//   tail_i     in  next write slot; the youngest entry sits at tail_i-1
//   addr_i     in  queried register specifier (zero never hits)
//   hit_o      out a pending write to addr_i exists
//   data_o     out youngest pending value, 0 on miss
// ----------------------------------------------------------------------------
module proc_wb_buffer_match
    import proc_wb_buffer_pkg::*;
#(
    parameter int p_num_entries = WB_NUM_ENTRIES
) (
    input  wb_entry_t                          entries_i [p_num_entries],
    input  logic [p_num_entries-1:0]           valid_i,
    input  logic [$clog2(p_num_entries)-1:0]   tail_i,
    input  logic [WB_ADDR_NBITS-1:0]           addr_i,
    output logic                               hit_o,
    output logic [WB_DATA_NBITS-1:0]           data_o
);

    localparam int PTR_W = $clog2(p_num_entries);

    logic [PTR_W-1:0] slot;

    // Walk from oldest (tail - N, i.e. tail itself when full) to youngest
    // (tail - 1); a later match overwrites an earlier one, so the youngest wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        slot   = '0;
        if (addr_i != REG_ZERO) begin
            for (int k = p_num_entries; k >= 1; k--) begin
                slot = tail_i - PTR_W'(k);
                if (valid_i[slot] && (entries_i[slot].addr == addr_i)) begin
                    hit_o  = 1'b1;
                    data_o = entries_i[slot].data;
                end
            end
        end
    end

endmodule

// File: rtl/proc_wb_buffer.sv
// ----------------------------------------------------------------------------
// proc_wb_buffer
//  In-order writeback queue in front of the register file write port.
//  Results arrive over a val/rdy handshake and drain at most one per cycle
//  when the regfile port is granted.
//  Build option: define PROC_WB_BUFFER_BYPASS_EN to enable the two
//  youngest-match bypass lookup ports; otherwise they read constant 0.
//  Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   enq_val/enq_rdy/enq_addr/enq_data  result input handshake
//   drain_en                        regfile write port granted this cycle
//   rf_wen/rf_waddr/rf_wdata        regfile write port (addr/data 0 when idle)
//   lookup_addr{0,1}/lookup_hit{0,1}/lookup_data{0,1}  bypass queries
//   count                           number of occupied entries
// ----------------------------------------------------------------------------
module proc_wb_buffer
    import proc_wb_buffer_pkg::*;
#(
    parameter int p_num_entries = WB_NUM_ENTRIES,
    parameter int p_data_nbits  = WB_DATA_NBITS,
    parameter int p_addr_nbits  = WB_ADDR_NBITS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enq_val,
    output logic                                  enq_rdy,
    input  logic [p_addr_nbits-1:0]               enq_addr,
    input  logic [p_data_nbits-1:0]               enq_data,
    input  logic                                  drain_en,
    output logic                                  rf_wen,
    output logic [p_addr_nbits-1:0]               rf_waddr,
    output logic [p_data_nbits-1:0]               rf_wdata,
    input  logic [p_addr_nbits-1:0]               lookup_addr0,
    output logic                                  lookup_hit0,
    output logic [p_data_nbits-1:0]               lookup_data0,
    input  logic [p_addr_nbits-1:0]               lookup_addr1,
    output logic                                  lookup_hit1,
    output logic [p_data_nbits-1:0]               lookup_data1,
    output logic [$clog2(p_num_entries+1)-1:0]    count
);

    localparam int PTR_W = $clog2(p_num_entries);
    localparam int CNT_W = $clog2(p_num_entries+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(p_num_entries);

    wb_entry_t        entries_q [p_num_entries];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drain;
    logic             enq_fire;
    logic             enq_store;
    wb_entry_t        head_entry;

    assign drain      = drain_en && (count_q != '0);
    // A slot freed by this cycle's drain can be refilled in the same cycle.
    assign enq_rdy    = (count_q != FULL_COUNT) || drain;
    assign enq_fire   = enq_val && enq_rdy;
    // Writes to the zero register complete the handshake but are dropped.
    assign enq_store  = enq_fire && (enq_addr != REG_ZERO);
    assign head_entry = entries_q[head_q];

    assign rf_wen   = drain;
    assign rf_waddr = drain ? head_entry.addr : '0;
    assign rf_wdata = drain ? head_entry.data : '0;
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq_store) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({enq_store, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: slot validity is derived from
    // head/count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (enq_store) begin
            entries_q[tail_q] <= '{addr: enq_addr, data: enq_data};
        end
    end

`ifdef PROC_WB_BUFFER_BYPASS_EN
    logic [p_num_entries-1:0]          slot_valid;
    logic [PTR_W-1:0]                  slot_off [p_num_entries];
    logic [1:0][p_addr_nbits-1:0]      query_addr;
    logic [1:0]                        query_hit;
    logic [1:0][p_data_nbits-1:0]      query_data;

    genvar gi;

    // A slot is occupied when its distance from head (mod depth) is below
    // count; when full, every distance 0..N-1 qualifies.
    for (gi = 0; gi < p_num_entries; gi++) begin : g_slot
        assign slot_off[gi]   = PTR_W'(gi) - head_q;
        assign slot_valid[gi] = (CNT_W'(slot_off[gi]) < count_q);
    end

    assign query_addr = {lookup_addr1, lookup_addr0};

    for (gi = 0; gi < 2; gi++) begin : g_port
        proc_wb_buffer_match #(
            .p_num_entries (p_num_entries)
        ) u_match (
            .entries_i (entries_q),
            .valid_i   (slot_valid),
            .tail_i    (tail_q),
            .addr_i    (query_addr[gi]),
            .hit_o     (query_hit[gi]),
            .data_o    (query_data[gi])
        );
    end

    assign lookup_hit0  = query_hit[0];
    assign lookup_data0 = query_data[0];
    assign lookup_hit1  = query_hit[1];
    assign lookup_data1 = query_data[1];
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup_addr0, lookup_addr1};

    assign lookup_hit0  = 1'b0;
    assign lookup_data0 = '0;
    assign lookup_hit1  = 1'b0;
    assign lookup_data1 = '0;
`endif

endmodule

// File: tb/tb_proc_wb_buffer.sv
module tb_proc_wb_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enq_val = 1'b0;
    logic        enq_rdy;
    logic [4:0]  enq_addr = '0;
    logic [31:0] enq_data = '0;
    logic        drain_en = 1'b0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  lookup_addr0 = '0;
    logic        lookup_hit0;
    logic [31:0] lookup_data0;
    logic [4:0]  lookup_addr1 = '0;
    logic        lookup_hit1;
    logic [31:0] lookup_data1;
    logic [2:0]  count;

    proc_wb_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .enq_val      (enq_val),
        .enq_rdy      (enq_rdy),
        .enq_addr     (enq_addr),
        .enq_data     (enq_data),
        .drain_en     (drain_en),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .lookup_addr0 (lookup_addr0),
        .lookup_hit0  (lookup_hit0),
        .lookup_data0 (lookup_data0),
        .lookup_addr1 (lookup_addr1),
        .lookup_hit1  (lookup_hit1),
        .lookup_data1 (lookup_data1),
        .count        (count)
    );

    always #5 clk = ~clk;

`ifdef PROC_WB_BUFFER_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    // Reference model: the queue of pending results, oldest at index 0.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  e_count;
    logic        e_rdy, e_wen, e_hit0, e_hit1;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata, e_data0, e_data1;

    task automatic set_in(input logic v, input logic [4:0] a, input logic [31:0] d,
                          input logic de, input logic [4:0] l0, input logic [4:0] l1);
        enq_val      = v;
        enq_addr     = a;
        enq_data     = d;
        drain_en     = de;
        lookup_addr0 = l0;
        lookup_addr1 = l1;
    endtask

    function automatic void ref_lookup(input logic [4:0] a, output logic h, output logic [31:0] dd);
        h  = 1'b0;
        dd = '0;
        if (BP && a != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].a == a) begin
                    h  = 1'b1;
                    dd = q[i].d;
                end
            end
        end
    endfunction

    task automatic predict();
        e_count = 3'(q.size());
        e_wen   = drain_en && (q.size() != 0);
        e_rdy   = (q.size() != 4) || e_wen;
        e_waddr = '0;
        e_wdata = '0;
        if (e_wen) begin
            e_waddr = q[0].a;
            e_wdata = q[0].d;
        end
        ref_lookup(lookup_addr0, e_hit0, e_data0);
        ref_lookup(lookup_addr1, e_hit1, e_data1);
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic tick();
        ent_t e;
        predict();
        @(posedge clk);
        if (reset) begin
            if (e_wen) void'(q.pop_front());
            if (enq_val && e_rdy && enq_addr != 5'd0) begin
                e.a = enq_addr;
                e.d = enq_data;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_in(1'b0, 5'd3, 32'h1234, 1'b1, 5'd3, 5'd4);
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b want 0", rf_wen); end
        checks++; if ({rf_waddr, rf_wdata} !== 37'd0) begin errors++; $display("FAIL reset_bus got %h/%h want 0/0", rf_waddr, rf_wdata); end
        checks++; if ({lookup_hit0, lookup_data0, lookup_hit1, lookup_data1} !== 66'd0) begin errors++; $display("FAIL reset_lookup got %b/%h want 0/0", lookup_hit0, lookup_data0); end
        @(negedge clk);
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        reset = 1'b1;
        #1;
        checks++; if (enq_rdy !== 1'b1) begin errors++; $display("FAIL release_rdy got %0b want 1", enq_rdy); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        set_in(1'b1, 5'd3, 32'hDEADBEEF, 1'b1, 5'd0, 5'd0);
        #1;
        checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL single_wen0 got %0b want 0", rf_wen); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        #1;
        checks++; if (rf_wen !== 1'b1) begin errors++; $display("FAIL single_wen1 got %0b want 1", rf_wen); end
        checks++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL single_waddr got %0d want 3", rf_waddr); end
        checks++; if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got %h want deadbeef", rf_wdata); end
        tick();
        #1;
        checks++; if (rf_wen !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL single_after got wen=%0b count=%0d want 0/0", rf_wen, count); end
        $display("test_single done");
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, 5'(i), $urandom, 1'b0, 5'd0, 5'd0);
            tick();
        end
        set_in(1'b1, 5'd5, $urandom, 1'b0, 5'd0, 5'd0);
        #1;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
        checks++; if (enq_rdy !== 1'b0) begin errors++; $display("FAIL full_rdy got %0b want 0", enq_rdy); end
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'(6 + i), $urandom, 1'b1, 5'd0, 5'd0);
            #1;
            checks++; if (enq_rdy !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL full_pass%0d got rdy=%0b count=%0d want 1/4", i, enq_rdy, count); end
            checks++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(i + 1)) begin errors++; $display("FAIL full_order%0d got wen=%0b addr=%0d want 1/%0d", i, rf_wen, rf_waddr, i + 1); end
            tick();
        end
        $display("test_full done");
    endtask

    task automatic test_drain_out();
        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
            #1;
            predict();
            checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {e_wen, e_waddr, e_wdata}) begin errors++; $display("FAIL drain_out got %0b/%0d/%h want %0b/%0d/%h", rf_wen, rf_waddr, rf_wdata, e_wen, e_waddr, e_wdata); end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_out_empty got %0d want 0", count); end
    endtask

    task automatic test_wrap();
        ent_t sent[$];
        ent_t got[$];
        ent_t e;
        for (int i = 0; i < 40 && got.size() < 6; i++) begin
            if (sent.size() < 6) set_in(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'(i % 2), 5'd0, 5'd0);
            else                 set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
            #1;
            if (rf_wen) begin
                e.a = rf_waddr;
                e.d = rf_wdata;
                got.push_back(e);
            end
            predict();
            if (enq_val && e_rdy) begin
                e.a = enq_addr;
                e.d = enq_data;
                sent.push_back(e);
            end
            tick();
        end
        checks++; if (got.size() != 6) begin errors++; $display("FAIL wrap_count got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (got[i].a !== sent[i].a || got[i].d !== sent[i].d) begin errors++; $display("FAIL wrap_entry%0d got %0d/%h want %0d/%h", i, got[i].a, got[i].d, sent[i].a, sent[i].d); end
        end
        $display("test_wrap done");
    endtask

    task automatic test_r0();
        set_in(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd0);
        tick();
        set_in(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 5'd0);
        #1;
        checks++; if (enq_rdy !== 1'b1) begin errors++; $display("FAIL r0_rdy got %0b want 1", enq_rdy); end
        tick();
        #1;
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL r0_count got %0d want 1", count); end
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
            #1;
            checks++; if (rf_wen !== (i == 0) || (rf_wen && rf_waddr !== 5'd7)) begin errors++; $display("FAIL r0_write%0d got wen=%0b addr=%0d want %0b/7", i, rf_wen, rf_waddr, i == 0); end
            tick();
        end
        $display("test_r0 done");
    endtask

    task automatic test_bypass();
        set_in(1'b1, 5'd5, 32'h11, 1'b0, 5'd5, 5'd6);
        #1;
        checks++; if (lookup_hit0 !== 1'b0) begin errors++; $display("FAIL bp_sameenq got %0b want 0", lookup_hit0); end
        tick();
        set_in(1'b1, 5'd5, 32'h22, 1'b0, 5'd5, 5'd6);
        #1;
        checks++; if (lookup_hit0 !== BP || lookup_data0 !== (BP ? 32'h11 : 32'h0)) begin errors++; $display("FAIL bp_first got %0b/%h want %0b/%h", lookup_hit0, lookup_data0, BP, BP ? 32'h11 : 32'h0); end
        tick();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd6);
        #1;
        checks++; if (lookup_hit0 !== BP || lookup_data0 !== (BP ? 32'h22 : 32'h0)) begin errors++; $display("FAIL bp_young got %0b/%h want %0b/%h", lookup_hit0, lookup_data0, BP, BP ? 32'h22 : 32'h0); end
        checks++; if (lookup_hit1 !== 1'b0 || lookup_data1 !== 32'h0) begin errors++; $display("FAIL bp_miss got %0b/%h want 0/0", lookup_hit1, lookup_data1); end
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd0);
        #1;
        checks++; if (lookup_hit1 !== 1'b0) begin errors++; $display("FAIL bp_r0 got %0b want 0", lookup_hit1); end
        tick();
        #1;
        checks++; if (rf_wen !== 1'b1 || lookup_hit0 !== BP || lookup_data0 !== (BP ? 32'h22 : 32'h0)) begin errors++; $display("FAIL bp_draining got wen=%0b %0b/%h want 1/%0b", rf_wen, lookup_hit0, lookup_data0, BP); end
        tick();
        #1;
        checks++; if (lookup_hit0 !== 1'b0 || lookup_data0 !== 32'h0) begin errors++; $display("FAIL bp_empty got %0b/%h want 0/0", lookup_hit0, lookup_data0); end
        $display("test_bypass done");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(10 + i), $urandom, 1'b0, 5'd0, 5'd0);
            tick();
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        #1;
        checks++; if (count !== 3'd3 || rf_wen !== 1'b1) begin errors++; $display("FAIL arst_pre got count=%0d wen=%0b want 3/1", count, rf_wen); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || rf_wen !== 1'b0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL arst_now got count=%0d wen=%0b addr=%0d want 0/0/0", count, rf_wen, rf_waddr); end
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (enq_rdy !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL arst_release got rdy=%0b count=%0d want 1/0", enq_rdy, count); end
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checks++; if (rf_wen !== 1'b0) begin errors++; $display("FAIL arst_nowrite%0d got %0b want 0", i, rf_wen); end
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            predict();
            checks++;
            if ({count, enq_rdy, rf_wen, rf_waddr, rf_wdata, lookup_hit0, lookup_data0, lookup_hit1, lookup_data1}
                !== {e_count, e_rdy, e_wen, e_waddr, e_wdata, e_hit0, e_data0, e_hit1, e_data1}) begin
                errors++;
                $display("FAIL random%0d got cnt=%0d rdy=%0b wen=%0b %0d/%h l0=%0b/%h l1=%0b/%h want cnt=%0d rdy=%0b wen=%0b %0d/%h l0=%0b/%h l1=%0b/%h",
                         i, count, enq_rdy, rf_wen, rf_waddr, rf_wdata, lookup_hit0, lookup_data0, lookup_hit1, lookup_data1,
                         e_count, e_rdy, e_wen, e_waddr, e_wdata, e_hit0, e_data0, e_hit1, e_data1);
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_drain_out();
        test_wrap();
        test_drain_out();
        test_r0();
        test_bypass();
        test_async_reset();
        test_random();
        test_drain_out();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
